// File: rtl/entity_pixel_decoder.sv
// Entity pixel decoder: sprite orientation/select, external sprite ROM fetch and palette lookup
// in a fixed 3-cycle pipeline. Define ENTITY_FRIGHT_EN to add the fright input and frightened ghost colours.
module entity_pixel_decoder #(
   parameter int ANIM_PERIOD = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [6:0]  entity_code,
   input  logic [1:0]  entity_dir,
   input  logic [9:0]  entity_x,
   input  logic [9:0]  entity_y,
   output logic [11:0] rom_addr,
   input  logic [1:0]  rom_data,
`ifdef ENTITY_FRIGHT_EN
   input  logic        fright,
`endif
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        rgb_valid
);

   logic [7:0]  frame_cnt_q;
   logic        phase_q;
   logic        s1_valid_q, s2_valid_q;
   logic [6:0]  s1_code_q, s2_code_q;
   logic        s1_fright_q, s2_fright_q;
   logic        fright_s0;
   logic [3:0]  x_s0, y_s0, row_d, col_d, sprite_d;
   logic [11:0] rom_addr_d;
   logic [23:0] body_rgb, rgb_d;
   logic        legal_s2, ghost_s2, scared_s2;
   logic        unused_coord_bits;

`ifdef ENTITY_FRIGHT_EN
   assign fright_s0 = fright;
`else
   assign fright_s0 = 1'b0;
`endif

   assign x_s0 = entity_x[3:0];
   assign y_s0 = entity_y[3:0];
   assign unused_coord_bits = ^{entity_x[9:4], entity_y[9:4]};

   // Stage 0: only pacman is rotated/mirrored; 15-v is the bitwise inverse of a 4-bit value.
   always_comb begin
      row_d    = y_s0;
      col_d    = x_s0;
      sprite_d = 4'd0;
      if (entity_code == 7'd1) begin
         case (entity_dir)
            2'd1: col_d = ~x_s0;
            2'd2: begin row_d = x_s0;  col_d = ~y_s0; end
            2'd3: begin row_d = ~x_s0; col_d = y_s0;  end
            default: ;
         endcase
      end
      case (entity_code)
         7'd1:                   sprite_d = {3'd0, phase_q};
         7'd2:                   sprite_d = 4'd2;
         7'd3, 7'd4, 7'd5, 7'd6: sprite_d = 4'd3 + {3'd0, phase_q};
         default:                sprite_d = 4'd0;
      endcase
      rom_addr_d = {sprite_d, row_d, col_d};
   end

   // Stage 3 palette uses the side-band code of the pixel whose ROM data is arriving now.
   always_comb begin
      legal_s2  = (s2_code_q >= 7'd1) && (s2_code_q <= 7'd6);
      ghost_s2  = (s2_code_q >= 7'd3) && (s2_code_q <= 7'd6);
      scared_s2 = ghost_s2 & s2_fright_q;
      case (s2_code_q)
         7'd1:    body_rgb = 24'hFFFF00;
         7'd2:    body_rgb = 24'h2121DE;
         7'd3:    body_rgb = 24'hFF0000;
         7'd4:    body_rgb = 24'hFFB8FF;
         7'd5:    body_rgb = 24'h00FFFF;
         7'd6:    body_rgb = 24'hFFB852;
         default: body_rgb = 24'h000000;
      endcase
      case (rom_data)
         2'd0:    rgb_d = 24'h000000;
         2'd1:    rgb_d = scared_s2 ? 24'h2121FF : body_rgb;
         2'd2:    rgb_d = scared_s2 ? 24'hFFB8AE : 24'hFFFFFF;
         default: rgb_d = 24'h2121FF;
      endcase
      if (!legal_s2) rgb_d = 24'h000000;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt_q <= 8'd0;
         phase_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s1_code_q   <= 7'd0;
         s2_code_q   <= 7'd0;
         s1_fright_q <= 1'b0;
         s2_fright_q <= 1'b0;
         rom_addr    <= 12'd0;
         red         <= 8'd0;
         green       <= 8'd0;
         blue        <= 8'd0;
         rgb_valid   <= 1'b0;
      end else begin
         if (frame_start) begin
            if (frame_cnt_q == 8'(ANIM_PERIOD - 1)) begin
               frame_cnt_q <= 8'd0;
               phase_q     <= ~phase_q;
            end else begin
               frame_cnt_q <= frame_cnt_q + 8'd1;
            end
         end
         s1_valid_q <= pix_valid;
         if (pix_valid) begin
            rom_addr    <= rom_addr_d;
            s1_code_q   <= entity_code;
            s1_fright_q <= fright_s0;
         end
         s2_valid_q  <= s1_valid_q;
         s2_code_q   <= s1_code_q;
         s2_fright_q <= s1_fright_q;
         rgb_valid   <= s2_valid_q;
         if (s2_valid_q) begin
            red   <= rgb_d[23:16];
            green <= rgb_d[15:8];
            blue  <= rgb_d[7:0];
         end
      end
   end

endmodule

// File: tb/tb_entity_pixel_decoder.sv
// Directed bench for entity_pixel_decoder: an in-bench ROM driver and a scoreboard monitor
// checking rom_addr one cycle and RGB three cycles after each pixel is sampled.
module tb_entity_pixel_decoder;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [6:0]  entity_code = 7'd0;
   logic [1:0]  entity_dir = 2'd0;
   logic [9:0]  entity_x = 10'd0;
   logic [9:0]  entity_y = 10'd0;
   logic [11:0] rom_addr;
   logic [1:0]  rom_data = 2'd0;
   logic        fright = 1'b0;
   logic [7:0]  red, green, blue;
   logic        rgb_valid;

   typedef struct {
      int          n;
      logic [11:0] addr;
      logic [1:0]  rd;
   } pix_t;

   pix_t        addr_q[$];
   pix_t        rd_q[$];
   logic [23:0] exp_q[$];
   int          exp_n_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [11:0] last_addr = 12'd0;
   logic [23:0] last_rgb = 24'd0;

   entity_pixel_decoder dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .entity_code (entity_code),
      .entity_dir  (entity_dir),
      .entity_x    (entity_x),
      .entity_y    (entity_y),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
`ifdef ENTITY_FRIGHT_EN
      .fright      (fright),
`endif
      .red         (red),
      .green       (green),
      .blue        (blue),
      .rgb_valid   (rgb_valid)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard monitor, sampled 1 time unit after each rising edge.
   always @(posedge Clk) begin
      pix_t e;
      cyc++;
      #1;
      if (addr_q.size() > 0 && addr_q[0].n == cyc - 1) begin
         e = addr_q.pop_front();
         check("rom_addr", {12'd0, rom_addr}, {12'd0, e.addr});
         last_addr = e.addr;
         rd_q.push_back(e);
      end else begin
         check("rom_addr_hold", {12'd0, rom_addr}, {12'd0, last_addr});
      end
      if (rd_q.size() > 0 && rd_q[0].n == cyc - 2) begin
         e = rd_q.pop_front();
         rom_data = e.rd;
      end
      if (rgb_valid) begin
         if (exp_q.size() == 0) begin
            check("rgb_unexpected", 24'd1, 24'd0);
         end else begin
            check("latency", 24'(cyc - exp_n_q[0]), 24'd3);
            check("rgb", {red, green, blue}, exp_q[0]);
            last_rgb = exp_q.pop_front();
            void'(exp_n_q.pop_front());
         end
      end else begin
         if (exp_n_q.size() > 0 && exp_n_q[0] + 3 <= cyc) begin
            check("rgb_missing", 24'd0, 24'd1);
            void'(exp_q.pop_front());
            void'(exp_n_q.pop_front());
         end
         check("rgb_hold", {red, green, blue}, last_rgb);
      end
   end

   task automatic pix_fs(input logic [6:0] code, input logic [1:0] dir, input logic [9:0] x,
                         input logic [9:0] y, input logic [1:0] rd, input logic [11:0] ea,
                         input logic [23:0] ergb, input logic fs);
      pix_t e;
      @(negedge Clk);
      entity_code = code;
      entity_dir  = dir;
      entity_x    = x;
      entity_y    = y;
      pix_valid   = 1'b1;
      frame_start = fs;
      e.n = cyc; e.addr = ea; e.rd = rd;
      addr_q.push_back(e);
      exp_q.push_back(ergb);
      exp_n_q.push_back(cyc);
   endtask

   task automatic pix(input logic [6:0] code, input logic [1:0] dir, input logic [9:0] x,
                      input logic [9:0] y, input logic [1:0] rd, input logic [11:0] ea,
                      input logic [23:0] ergb);
      pix_fs(code, dir, x, y, rd, ea, ergb, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         pix_valid   = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         pix_valid   = 1'b0;
         frame_start = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      check("reset_addr", {12'd0, rom_addr}, 24'd0);
      check("reset_valid", {23'd0, rgb_valid}, 24'd0);
      check("reset_rgb", {red, green, blue}, 24'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Blinky before any frame pulses, then pacman in all four directions.
      pix(7'd3, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'hFF0000);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h053, 24'hFFFF00);
      pix(7'd1, 2'd1, 10'd3, 10'd5, 2'd1, 12'h05C, 24'hFFFF00);
      pix(7'd1, 2'd2, 10'd3, 10'd5, 2'd1, 12'h03A, 24'hFFFF00);
      pix(7'd1, 2'd3, 10'd3, 10'd5, 2'd1, 12'h0C5, 24'hFFFF00);
      pix(7'd1, 2'd2, 10'h3FA, 10'h2A1, 2'd2, 12'h0AE, 24'hFFFFFF);
      // Palette indices, body colours, none/illegal codes, ghost direction ignored.
      pix(7'd3, 2'd2, 10'd3, 10'd5, 2'd0, 12'h353, 24'h000000);
      pix(7'd3, 2'd0, 10'd3, 10'd5, 2'd3, 12'h353, 24'h2121FF);
      pix(7'd0, 2'd1, 10'd3, 10'd5, 2'd1, 12'h053, 24'h000000);
      pix(7'd7, 2'd0, 10'd3, 10'd5, 2'd2, 12'h053, 24'h000000);
      pix(7'd2, 2'd0, 10'd3, 10'd5, 2'd1, 12'h253, 24'h2121DE);
      pix(7'd4, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'hFFB8FF);
      pix(7'd5, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'h00FFFF);
      pix(7'd6, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'hFFB852);
      idle(2);
      // Streaming: 4 valid, 1 idle, 2 valid.
      pix(7'd2, 2'd0, 10'd0, 10'd0, 2'd1, 12'h200, 24'h2121DE);
      pix(7'd4, 2'd0, 10'd15, 10'd15, 2'd2, 12'h3FF, 24'hFFFFFF);
      pix(7'd1, 2'd3, 10'd0, 10'd15, 2'd1, 12'h0FF, 24'hFFFF00);
      pix(7'd6, 2'd0, 10'd7, 10'd8, 2'd1, 12'h387, 24'hFFB852);
      idle(1);
      pix(7'd5, 2'd0, 10'd1, 10'd2, 2'd3, 12'h321, 24'h2121FF);
      pix(7'd3, 2'd0, 10'd4, 10'd4, 2'd0, 12'h344, 24'h000000);
      idle(4);
      // Animation: the 8th pulse coincides with a pixel that still uses phase 0.
      pulses(7);
      pix_fs(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h053, 24'hFFFF00, 1'b1);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h153, 24'hFFFF00);
      pix(7'd3, 2'd0, 10'd3, 10'd5, 2'd1, 12'h453, 24'hFF0000);
      pulses(8);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h053, 24'hFFFF00);
      pix(7'd3, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'hFF0000);
      pulses(8);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h153, 24'hFFFF00);
      idle(4);
      pulses(3);
      // Reset in the middle of a pixel stream; in-flight pixels are dropped.
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h153, 24'hFFFF00);
      pix(7'd3, 2'd0, 10'd3, 10'd5, 2'd1, 12'h453, 24'hFF0000);
      pix(7'd2, 2'd0, 10'd3, 10'd5, 2'd1, 12'h253, 24'h2121DE);
      #2;
      Reset_n = 1'b0;
      addr_q.delete();
      rd_q.delete();
      exp_q.delete();
      exp_n_q.delete();
      last_addr = 12'd0;
      last_rgb  = 24'd0;
      #1;
      check("midrst_addr", {12'd0, rom_addr}, 24'd0);
      check("midrst_valid", {23'd0, rgb_valid}, 24'd0);
      check("midrst_rgb", {red, green, blue}, 24'd0);
      @(negedge Clk);
      @(negedge Clk);
      pix_valid = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h053, 24'hFFFF00);
`ifdef ENTITY_FRIGHT_EN
      fright = 1'b1;
      pix(7'd5, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'h2121FF);
      pix(7'd5, 2'd0, 10'd3, 10'd5, 2'd2, 12'h353, 24'hFFB8AE);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h053, 24'hFFFF00);
      pix(7'd2, 2'd0, 10'd3, 10'd5, 2'd1, 12'h253, 24'h2121DE);
      idle(1);
      fright = 1'b0;
      pix(7'd5, 2'd0, 10'd3, 10'd5, 2'd1, 12'h353, 24'h00FFFF);
`endif
      // Frame counter restarted at 0: 7 pulses keep phase 0, the 8th toggles it.
      idle(4);
      pulses(7);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h053, 24'hFFFF00);
      pulses(1);
      pix(7'd1, 2'd0, 10'd3, 10'd5, 2'd1, 12'h153, 24'hFFFF00);
      pix(7'd3, 2'd0, 10'd3, 10'd5, 2'd1, 12'h453, 24'hFF0000);
      idle(6);
      check("drain", 24'(exp_q.size() + addr_q.size()), 24'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
